// File: rtl/rv32_div_seq.sv
// Purpose: multi-cycle DIV/DIVU/REM/REMU sequencer (radix-2 restoring) for the RV32 M extension.
// Latency: accept -> rsp_valid_o in XLEN+1 cycles; divide-by-zero and signed overflow in 1 cycle.
// Backpressure: result and tag are held in DONE until rsp_ready_i; no new request is accepted until IDLE.
//
// Ports:
//   clk, rst                   core clock, synchronous active-high reset
//   req_valid_i / req_ready_o  request handshake (ready only in IDLE)
//   op_i, rs1_i, rs2_i, tag_i  operation (00 DIV, 01 DIVU, 10 REM, 11 REMU), dividend, divisor, dest tag
//   flush_i                    abandon any operation, highest priority
//   rsp_valid_o / rsp_ready_i  response handshake
//   result_o, tag_o            registered quotient/remainder and captured tag
//   busy_o                     high in CALC or DONE
module rv32_div_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;       // partial remainder, always < divisor
    logic [XLEN-1:0]  quo_q, quo_d;       // dividend bits shifting out, quotient bits shifting in
    logic [XLEN-1:0]  dvs_q, dvs_d;       // divisor magnitude
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             rem_sel_q, rem_sel_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            accept;
    logic            is_signed;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic            div_zero, sgn_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            last_iter;

    assign accept    = req_valid_i && req_ready_o && !flush_i;
    assign is_signed = ~op_i[0];
    assign rs1_neg   = is_signed & rs1_i[XLEN-1];
    assign rs2_neg   = is_signed & rs2_i[XLEN-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign rs1_mag   = rs1_neg ? -rs1_i : rs1_i;
    assign rs2_mag   = rs2_neg ? -rs2_i : rs2_i;

    assign div_zero  = (rs2_i == '0);
    assign sgn_ovf   = is_signed && (rs1_i == XLEN_MIN) && (rs2_i == '1);
    assign special   = div_zero || sgn_ovf;

    // Divide by zero wins over overflow: divisor 0 can never also be all ones.
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op_i[1] ? rs1_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : XLEN_MIN;
        end
    end

    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // ------------------------------------------------------------------
    // One restoring step. The shifted remainder needs XLEN+1 bits because
    // it can reach 2*divisor-1 before the trial subtraction.
    // ------------------------------------------------------------------
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign rem_step = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ~trial[XLEN]};
    assign quo_fix  = (dvd_neg_q ^ dvs_neg_q) ? -quo_step : quo_step;
    assign rem_fix  = dvd_neg_q ? -rem_step : rem_step;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state (flush outranks accept and the response handshake)
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
                S_CALC:  if (last_iter) state_d = S_DONE;
                S_DONE:  if (rsp_ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        rem_sel_d = rem_sel_q;
        result_d  = result_q;
        tag_d     = tag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tag_d     = tag_i;
                    rem_sel_d = op_i[1];
                    dvd_neg_d = rs1_neg;
                    dvs_neg_d = rs2_neg;
                    dvs_d     = rs2_mag;
                    quo_d     = rs1_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (special) begin
                        result_d = special_res;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                // Sign correction folded into the final iteration's result load.
                if (last_iter) begin
                    result_d = rem_sel_q ? rem_fix : quo_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            rem_sel_q <= rem_sel_d;
            result_q  <= result_d;
            tag_q     <= tag_d;
        end
    end

    assign result_o = result_q;
    assign tag_o    = tag_q;

endmodule

// File: doc/rv32_div_seq.md
Name: rv32_div_seq

Overview:
- Multi-cycle sequencer for the M-extension DIV/DIVU/REM/REMU operations in the RV32IMACZicsr core.
- Accepts an operation issued from the decode stage over a valid/ready handshake.
- Runs a radix-2 restoring division for XLEN cycles, or short-circuits the special cases, then holds the result until writeback accepts it.
- Owns the divider's state machine, iteration counter and sign correction.

Parameters:
- XLEN, 32: operand and result width in bits.
- TAG_W, 5: width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  decode presents a divide operation.
- req_ready_o  out  1  sequencer can accept; high only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_i  in  XLEN  dividend.
- rs2_i  in  XLEN  divisor.
- tag_i  in  TAG_W  destination register index.
- flush_i  in  1  pipeline flush; abandon any operation in progress.
- rsp_valid_o  out  1  result available.
- rsp_ready_i  in  1  writeback accepts the result.
- result_o  out  XLEN  quotient or remainder.
- tag_o  out  TAG_W  tag captured at accept.
- busy_o  out  1  high in CALC or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, req_ready_o=1, rsp_valid_o=0, busy_o=0, result_o=0, tag_o=0, counter=0.
- States and transitions:
  - IDLE: on accept, go to DONE if the operation is a special case, else go to CALC.
  - CALC: iterate; after the iteration with cnt==XLEN-1, go to DONE.
  - DONE: on rsp_valid_o && rsp_ready_i, go to IDLE.
- Accept: req_valid_i && req_ready_o && !flush_i.
  - Capture op, tag, the operand magnitudes and the sign flags.
  - Signed ops: sign flag = operand MSB; magnitude = two's-complement absolute value.
  - Unsigned ops: sign flags = 0.
- Special cases are detected at accept and skip CALC; DONE is entered the next cycle:
  - Divisor == 0: quotient = all ones; remainder = rs1_i, unmodified.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC step, once per cycle, on {rem, quo} with rem XLEN+1 bits wide:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor.
  - If trial >= 0: rem = trial and quo[0] = 1.
  - The counter increments from 0 to XLEN-1 and is cleared on entry to CALC.
- Sign correction, applied on transition to DONE:
  - Quotient is negated when the dividend and divisor sign flags differ.
  - Remainder is negated when the dividend sign flag is set.
  - result_o = quotient for DIV/DIVU, remainder for REM/REMU.
- Latency, from the accept edge to rsp_valid_o high:
  - Special cases: 1 cycle.
  - Normal operations: XLEN+1 cycles (33 for the default XLEN).
- Output handshake:
  - rsp_valid_o is high exactly in DONE.
  - result_o and tag_o are registered and stable while rsp_valid_o && !rsp_ready_i.
  - req_ready_o = (state==IDLE), so a new request is never accepted in the same cycle as a response handshake.
  - After a handshake, req_ready_o rises on the next cycle.
- Flush:
  - flush_i in any state forces IDLE on the next edge and discards the result.
  - rsp_valid_o drops on that edge.
  - flush_i has priority over both accept and response handshake in the same cycle.
- Reset mid-operation: identical to flush; all outputs return to their reset values.
- Width rule: internal subtraction is XLEN+1 bits wide; no truncation of intermediate remainders.
- busy_o = (state != IDLE).

Test Plan:
- DIVU 100/7, then REMU 100/7, with rsp_ready_i=1 -> results 14 and 2; rsp_valid_o rises exactly 33 cycles after each accept and stays high for 1 cycle.
- DIV -7/2 and REM -7/2 -> 0xFFFFFFFD and 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 0x00000001.
- Divide by zero -> DIVU 0x1234/0 gives 0xFFFFFFFF; REM 5/0 gives 5; DIV -5/0 gives 0xFFFFFFFF; each with 1-cycle latency.
- Overflow: DIV and REM of 0x80000000 by 0xFFFFFFFF -> 0x80000000 and 0; 1-cycle latency; CALC never entered.
- Backpressure: hold rsp_ready_i=0 for 10 cycles in DONE -> rsp_valid_o stays 1, result_o/tag_o unchanged, req_ready_o=0 throughout; after the handshake, req_ready_o=1 on the next cycle; a back-to-back request completes correctly.
- Flush and reset: assert flush_i on CALC cycle 10 -> rsp_valid_o never rises and req_ready_o=1 on the next cycle; a following DIVU 100/7 returns 14. Repeat with rst mid-CALC and with flush_i coincident with req_valid_i -> no accept occurs.
